// File: rtl/addr_gen_bank.sv
// Multi-channel strided address generator with per-channel base/stride.
// Define ADDR_GEN_BOUND_EN for bounded (limit-checked) addressing.
module addr_gen_bank #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 2,
  parameter int CH_W       = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [CH_W-1:0]              ld_ch,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         stride_we,
  input  logic                         limit_we,
  input  logic                         inc,
  input  logic [CH_W-1:0]              inc_ch,
  output logic [NUM_CH*DATA_WIDTH-1:0] addr_out,
  output logic [NUM_CH-1:0]            wrap
);

  logic [DATA_WIDTH-1:0] r_addr   [NUM_CH];
  logic [DATA_WIDTH-1:0] r_base   [NUM_CH];
  logic [DATA_WIDTH-1:0] r_stride [NUM_CH];
  logic [NUM_CH-1:0]     r_wrap;

  logic [NUM_CH-1:0]     w_cfg_hit;
  logic [NUM_CH-1:0]     w_ld_hit;
  logic [NUM_CH-1:0]     w_inc_hit;
  logic [NUM_CH-1:0]     w_over;
  logic [NUM_CH-1:0]     w_wrap_nxt;
  logic [DATA_WIDTH:0]   w_sum      [NUM_CH];
  logic [DATA_WIDTH-1:0] w_inc_addr [NUM_CH];

`ifdef ADDR_GEN_BOUND_EN
  logic [DATA_WIDTH-1:0] r_limit [NUM_CH];
`else
  logic w_unused_limit_we;
  assign w_unused_limit_we = limit_we;
`endif

  // Out-of-range channel selects match no k, so they fall through as no-ops.
  always_comb begin
    w_cfg_hit  = '0;
    w_ld_hit   = '0;
    w_inc_hit  = '0;
    w_over     = '0;
    w_wrap_nxt = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      w_cfg_hit[k] = (ld_ch == CH_W'(k));
      w_ld_hit[k]  = we && w_cfg_hit[k];
      w_inc_hit[k] = inc && (inc_ch == CH_W'(k));
      w_sum[k]     = {1'b0, r_addr[k]} + {1'b0, r_stride[k]};
`ifdef ADDR_GEN_BOUND_EN
      w_over[k]     = w_sum[k] > {1'b0, r_limit[k]};
      w_inc_addr[k] = w_over[k] ? r_base[k]
                                : w_sum[k][DATA_WIDTH-1:0];
`else
      w_over[k]     = w_sum[k][DATA_WIDTH];
      w_inc_addr[k] = w_sum[k][DATA_WIDTH-1:0];
`endif
      w_wrap_nxt[k] = w_inc_hit[k] && !w_ld_hit[k] && w_over[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrap <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_addr[k]   <= '0;
        r_base[k]   <= '0;
        r_stride[k] <= DATA_WIDTH'(1);
`ifdef ADDR_GEN_BOUND_EN
        r_limit[k]  <= '1;
`endif
      end
    end else begin
      r_wrap <= w_wrap_nxt;
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_ld_hit[k]) begin
          r_addr[k] <= data_in;
          r_base[k] <= data_in;
        end else if (w_inc_hit[k]) begin
          r_addr[k] <= w_inc_addr[k];
        end
        if (stride_we && w_cfg_hit[k])
          r_stride[k] <= data_in;
`ifdef ADDR_GEN_BOUND_EN
        if (limit_we && w_cfg_hit[k])
          r_limit[k] <= data_in;
`endif
      end
    end
  end

  always_comb begin
    addr_out = '0;
    for (int k = 0; k < NUM_CH; k++)
      addr_out[k*DATA_WIDTH +: DATA_WIDTH] = r_addr[k];
  end

  assign wrap = r_wrap;

endmodule

// File: tb/tb_addr_gen_bank.sv
// Directed self-checking bench for addr_gen_bank (default 2 x 16-bit).
// Bounded-mode scenarios build only when ADDR_GEN_BOUND_EN is defined.
module tb_addr_gen_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [0:0]  ld_ch;
  logic [15:0] data_in;
  logic        stride_we;
  logic        limit_we;
  logic        inc;
  logic [0:0]  inc_ch;
  logic [31:0] addr_out;
  logic [1:0]  wrap;

  int tests = 0;
  int fails = 0;

  addr_gen_bank #(
    .DATA_WIDTH(16),
    .NUM_CH(2),
    .CH_W(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .we(we),
    .ld_ch(ld_ch),
    .data_in(data_in),
    .stride_we(stride_we),
    .limit_we(limit_we),
    .inc(inc),
    .inc_ch(inc_ch),
    .addr_out(addr_out),
    .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; we = 0; stride_we = 0; limit_we = 0; inc = 0;
    ld_ch = 0; inc_ch = 0; data_in = 16'h0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;
    tests++;
    if (addr_out !== 32'h0) begin
      fails++;
      $display("FAIL reset_addr got %h exp %h", addr_out, 32'h0);
    end
    tests++;
    if (wrap !== 2'b00) begin
      fails++;
      $display("FAIL reset_wrap got %b exp %b", wrap, 2'b00);
    end
  endtask

  task automatic test_load();
    we = 1; ld_ch = 1; data_in = 16'h0040;
    tick();
    idle();
    tests++;
    if (addr_out !== 32'h0040_0000) begin
      fails++;
      $display("FAIL load_ch1 got %h exp %h", addr_out, 32'h0040_0000);
    end
    tests++;
    if (wrap !== 2'b00) begin
      fails++;
      $display("FAIL load_wrap got %b exp %b", wrap, 2'b00);
    end
  endtask

  task automatic test_stride();
    logic [15:0] exp [3];
    exp[0] = 16'h0014; exp[1] = 16'h0018; exp[2] = 16'h001C;
    we = 1; stride_we = 1; ld_ch = 0; data_in = 16'h0010;
    tick();
    stride_we = 1; we = 0; data_in = 16'h0004;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      inc = 1; inc_ch = 0;
      tick();
      idle();
      tests++;
      if (addr_out[15:0] !== exp[i] || addr_out[31:16] !== 16'h0040) begin
        fails++;
        $display("FAIL stride_inc%0d got %h exp %h_%h",
                 i, addr_out, 16'h0040, exp[i]);
      end
    end
  endtask

  task automatic test_stride_timing();
    stride_we = 1; ld_ch = 0; data_in = 16'h0008;
    inc = 1; inc_ch = 0;
    tick();
    tests++;
    if (addr_out[15:0] !== 16'h0020) begin
      fails++;
      $display("FAIL stride_old got %h exp %h", addr_out[15:0], 16'h0020);
    end
    idle();
    inc = 1; inc_ch = 0;
    tick();
    idle();
    tests++;
    if (addr_out[15:0] !== 16'h0028) begin
      fails++;
      $display("FAIL stride_new got %h exp %h", addr_out[15:0], 16'h0028);
    end
  endtask

  task automatic test_back_to_back();
    we = 1; ld_ch = 0; data_in = 16'h0100;
    inc = 1; inc_ch = 0;
    tick();
    idle();
    tests++;
    if (addr_out[15:0] !== 16'h0100 || wrap !== 2'b00) begin
      fails++;
      $display("FAIL same_ch_load got %h/%b exp %h/%b",
               addr_out[15:0], wrap, 16'h0100, 2'b00);
    end
    we = 1; ld_ch = 0; data_in = 16'h0200;
    inc = 1; inc_ch = 1;
    tick();
    idle();
    tests++;
    if (addr_out !== 32'h0041_0200) begin
      fails++;
      $display("FAIL diff_ch got %h exp %h", addr_out, 32'h0041_0200);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_a;
`ifdef ADDR_GEN_BOUND_EN
    exp_a = 16'hFFFE;
`else
    exp_a = 16'h0002;
`endif
    we = 1; stride_we = 1; ld_ch = 1; data_in = 16'hFFFE;
    tick();
    stride_we = 1; we = 0; data_in = 16'h0004;
    tick();
    idle();
    inc = 1; inc_ch = 1;
    tick();
    idle();
    tests++;
    if (addr_out[31:16] !== exp_a || wrap !== 2'b10) begin
      fails++;
      $display("FAIL wrap_ch1 got %h/%b exp %h/%b",
               addr_out[31:16], wrap, exp_a, 2'b10);
    end
    tick();
    tests++;
    if (wrap !== 2'b00 || addr_out[31:16] !== exp_a) begin
      fails++;
      $display("FAIL wrap_pulse got %h/%b exp %h/%b",
               addr_out[31:16], wrap, exp_a, 2'b00);
    end
  endtask

`ifdef ADDR_GEN_BOUND_EN
  task automatic test_bound();
    logic [15:0] exp [3];
    logic [1:0]  expw [3];
    exp[0] = 16'h0014; exp[1] = 16'h0018; exp[2] = 16'h0010;
    expw[0] = 2'b00; expw[1] = 2'b00; expw[2] = 2'b01;
    we = 1; ld_ch = 0; data_in = 16'h0010;
    tick();
    we = 0; stride_we = 1; data_in = 16'h0004;
    tick();
    stride_we = 0; limit_we = 1; data_in = 16'h0018;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      inc = 1; inc_ch = 0;
      tick();
      idle();
      tests++;
      if (addr_out[15:0] !== exp[i] || wrap !== expw[i]) begin
        fails++;
        $display("FAIL bound_inc%0d got %h/%b exp %h/%b",
                 i, addr_out[15:0], wrap, exp[i], expw[i]);
      end
    end
    tick();
    tests++;
    if (wrap !== 2'b00) begin
      fails++;
      $display("FAIL bound_pulse got %b exp %b", wrap, 2'b00);
    end
  endtask
`endif

  task automatic test_reset_priority();
    rst = 1; we = 1; ld_ch = 0; data_in = 16'h0055;
    stride_we = 1; limit_we = 1; inc = 1; inc_ch = 1;
    tick();
    idle();
    tests++;
    if (addr_out !== 32'h0 || wrap !== 2'b00) begin
      fails++;
      $display("FAIL rst_prio got %h/%b exp %h/%b",
               addr_out, wrap, 32'h0, 2'b00);
    end
    we = 1; ld_ch = 1; data_in = 16'hFFFF;
    tick();
    idle();
    rst = 1; inc = 1; inc_ch = 1;
    tick();
    idle();
    tests++;
    if (addr_out !== 32'h0 || wrap !== 2'b00) begin
      fails++;
      $display("FAIL rst_drop_wrap got %h/%b exp %h/%b",
               addr_out, wrap, 32'h0, 2'b00);
    end
    inc = 1; inc_ch = 0;
    tick();
    inc = 1; inc_ch = 1;
    tick();
    idle();
    tests++;
    if (addr_out !== 32'h0001_0001 || wrap !== 2'b00) begin
      fails++;
      $display("FAIL rst_stride1 got %h/%b exp %h/%b",
               addr_out, wrap, 32'h0001_0001, 2'b00);
    end
  endtask

  initial begin
    idle();
    test_reset();
    test_load();
    test_stride();
    test_stride_timing();
    test_back_to_back();
    test_wrap();
`ifdef ADDR_GEN_BOUND_EN
    test_bound();
`endif
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addr_gen_bank.md
ADDR_GEN_BANK -- requirements
Module: addr_gen_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning width of every address, stride and limit register.
REQ-002 SHALL have parameter NUM_CH, default 2, meaning number of address channels (ch0 = instruction memory, ch1 = data memory).
REQ-003 SHALL have parameter CH_W, default 1, meaning channel-select width; at least 1 and at least clog2(NUM_CH).
REQ-004 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port: we  input  1  load enable; load data_in into address of channel ld_ch.
REQ-007 SHALL have port: ld_ch  input  CH_W  channel for load, stride write and limit write.
REQ-008 SHALL have port: data_in  input  DATA_WIDTH  load/config data.
REQ-009 SHALL have port: stride_we  input  1  write data_in into stride of ld_ch.
REQ-010 SHALL have port: limit_we  input  1  write data_in into limit of ld_ch (ignored when ADDR_GEN_BOUND_EN undefined).
REQ-011 SHALL have port: inc  input  1  advance address of channel inc_ch by its stride.
REQ-012 SHALL have port: inc_ch  input  CH_W  channel to advance.
REQ-013 SHALL have port: addr_out  output  NUM_CH*DATA_WIDTH  registered addresses; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-014 SHALL have port: wrap  output  NUM_CH  registered one-cycle wrap pulse per channel.

Function
REQ-015 Per channel, SHALL hold registers addr, base, stride and limit (limit only with ADDR_GEN_BOUND_EN).
REQ-016 we=1: addr[ld_ch] and base[ld_ch] SHALL both take data_in; visible on addr_out next cycle (latency 1).
REQ-017 inc=1 without wrap: addr[inc_ch] SHALL become addr+stride, modulo 2^DATA_WIDTH.
REQ-018 we and inc in the same cycle on the same channel: load SHALL win; no increment, no wrap pulse.
REQ-019 we and inc in the same cycle on different channels: both SHALL take effect.
REQ-020 stride_we and limit_we SHALL be independent of we/inc in the same cycle; a stride written this cycle SHALL first apply to the next cycle's inc.
REQ-021 ld_ch or inc_ch >= NUM_CH SHALL make that operation a no-op.
REQ-022 wrap[k] SHALL be 1 for exactly the cycle after an increment of channel k wraps, otherwise 0.
REQ-023 Untouched channels SHALL hold their values.

Reset
REQ-024 On rst=1 at a clk edge: all addr=0, base=0, stride=1, limit=all ones, wrap=0.
REQ-025 rst SHALL take priority over we, inc, stride_we and limit_we in the same cycle; reset mid-sequence SHALL drop any wrap pending.

Configuration
REQ-026 Macro ADDR_GEN_BOUND_EN SHALL select bounded addressing.
REQ-027 Defined: on inc, if addr+stride computed in DATA_WIDTH+1 bits (unsigned) > limit, addr SHALL become base and wrap SHALL pulse; equal to limit is not a wrap.
REQ-028 Undefined: no limit registers, limit_we ignored, addr wraps modulo 2^DATA_WIDTH, and wrap SHALL pulse when the DATA_WIDTH+1-bit sum carries out.

Verification
REQ-029 rst, then we=1, ld_ch=1, data_in=0x0040 -> next cycle ch1=0x0040, ch0=0x0000, wrap=00.
REQ-030 ch0 loaded 0x0010, stride_we with 4, then three incs on ch0 -> ch0 goes 0x0014, 0x0018, 0x001C.
REQ-031 Bound on: ch0 base 0x0010, limit 0x0018, stride 4 -> incs give 0x0014, 0x0018, then 0x0010 with wrap[0]=1 for one cycle.
REQ-032 Same-cycle we (ch0, 0x0100) and inc on ch0 -> ch0=0x0100, no wrap; we on ch0 with inc on ch1 -> both update.
REQ-033 Bound off: ch1=0xFFFE, stride 4, inc -> ch1=0x0002 with wrap[1]=1.
REQ-034 rst asserted together with we and inc -> all addr 0, stride 1, wrap 0 next cycle.
